// File: rtl/core_mem_s.sv
// MEM stage: launches one L1D request per memory instruction, waits for the data and registers the W-stage result.
// Optional CORE_MEM_MISALIGN_CHK_EN rejects misaligned half/word requests in IDLE and pulses mem_misalign_err.
module core_mem_s (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_enb,
  input  logic        mem_kill,
  input  logic [6:0]  mem_l1d_bus_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] mem_w_data_in,
  input  logic [31:0] mem_alu_result_in,
  input  logic [31:0] mem_pc_4_in,
  input  logic [2:0]  mem_wb_sx_op_in,
  input  logic        mem_we_reg_file_in,
  input  logic        mem_mux_alu_mem_in,
  output logic        l1d_req_val,
  output logic        l1d_req_we,
  output logic [1:0]  l1d_req_size,
  output logic [31:0] l1d_req_addr,
  output logic [31:0] l1d_req_wdata,
  input  logic        l1d_req_ack,
  input  logic        l1d_ack,
  input  logic [31:0] l1d_ack_data,
  output logic        mem_stall,
  output logic [31:0] mem2haz_result_frm_m,
  output logic [31:0] mem_result_out_reg,
  output logic        mem_we_reg_file_out_reg,
  output logic        mem_misalign_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] b_addr, b_wdata, ld_buf, ld_ext;
  logic        b_wr, b_we, b_mux, kill_flag;
  logic [1:0]  b_size;
  logic [2:0]  b_sx;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        misalign, launch, mis_req, upd;

  logic unused_ok;
  assign unused_ok = ^{mem_pc_4_in, mem_l1d_bus_in[6:4]};

`ifdef CORE_MEM_MISALIGN_CHK_EN
  assign misalign = (mem_l1d_bus_in[3:2] == 2'b01 && mem_addr_in[0]) ||
                    (mem_l1d_bus_in[3:2] == 2'b10 && mem_addr_in[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign launch    = (state == IDLE) && mem_l1d_bus_in[0] && !mem_kill && !misalign;
  assign mis_req   = (state == IDLE) && mem_l1d_bus_in[0] && !mem_kill && misalign;
  assign mem_stall = launch || (state == REQ) || (state == WAIT);
  assign upd       = mem_enb && !mem_stall;

  assign mem2haz_result_frm_m = mem_alu_result_in;
  assign l1d_req_val   = (state == REQ);
  assign l1d_req_we    = b_wr;
  assign l1d_req_size  = b_size;
  assign l1d_req_addr  = b_addr;
  assign l1d_req_wdata = b_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (launch) state_nxt = REQ;
      REQ:  if (l1d_req_ack) state_nxt = b_wr ? DONE : WAIT;
      WAIT: if (l1d_ack) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_addr  <= '0;
      b_wdata <= '0;
      b_wr    <= 1'b0;
      b_size  <= '0;
      b_sx    <= '0;
      b_we    <= 1'b0;
      b_mux   <= 1'b0;
      ld_buf  <= '0;
    end else begin
      if (launch) begin
        b_addr  <= mem_addr_in;
        b_wdata <= mem_w_data_in;
        b_wr    <= mem_l1d_bus_in[1];
        b_size  <= mem_l1d_bus_in[3:2];
        b_sx    <= mem_wb_sx_op_in;
        b_we    <= mem_we_reg_file_in;
        b_mux   <= mem_mux_alu_mem_in;
      end
      if (state == WAIT && l1d_ack) ld_buf <= l1d_ack_data;
    end
  end

  // A kill while the L1D owns the request is remembered and applied in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            kill_flag <= 1'b0;
    else if (state == REQ || state == WAIT) kill_flag <= kill_flag | mem_kill;
    else                                   kill_flag <= 1'b0;
  end

  always_comb begin
    case (b_addr[1:0])
      2'd0:    ld_byte = ld_buf[7:0];
      2'd1:    ld_byte = ld_buf[15:8];
      2'd2:    ld_byte = ld_buf[23:16];
      default: ld_byte = ld_buf[31:24];
    endcase
    ld_half = b_addr[1] ? ld_buf[31:16] : ld_buf[15:0];
    case (b_sx)
      3'b001:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b010:  ld_ext = {24'd0, ld_byte};
      3'b011:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {16'd0, ld_half};
      default: ld_ext = ld_buf;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_result_out_reg      <= '0;
      mem_we_reg_file_out_reg <= 1'b0;
    end else if (upd) begin
      if (state == DONE) begin
        if (kill_flag || mem_kill) begin
          mem_result_out_reg      <= '0;
          mem_we_reg_file_out_reg <= 1'b0;
        end else begin
          mem_result_out_reg      <= b_mux ? ld_ext : mem_alu_result_in;
          mem_we_reg_file_out_reg <= b_we;
        end
      end else if (mem_kill || mis_req) begin
        mem_result_out_reg      <= '0;
        mem_we_reg_file_out_reg <= 1'b0;
      end else begin
        mem_result_out_reg      <= mem_alu_result_in;
        mem_we_reg_file_out_reg <= mem_we_reg_file_in;
      end
    end
  end

`ifdef CORE_MEM_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_misalign_err <= 1'b0;
    else        mem_misalign_err <= mis_req;
  end
`else
  assign mem_misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_core_mem_s.sv
// Bench for core_mem_s: directed vector table, hand sequences for kill/reset/misalign, randomized loads/stores vs a model.
module tb_core_mem_s;
  logic        clk, rst_n, mem_enb, mem_kill;
  logic [6:0]  mem_l1d_bus_in;
  logic [31:0] mem_addr_in, mem_w_data_in, mem_alu_result_in, mem_pc_4_in;
  logic [2:0]  mem_wb_sx_op_in;
  logic        mem_we_reg_file_in, mem_mux_alu_mem_in;
  logic        l1d_req_val, l1d_req_we;
  logic [1:0]  l1d_req_size;
  logic [31:0] l1d_req_addr, l1d_req_wdata;
  logic        l1d_req_ack, l1d_ack;
  logic [31:0] l1d_ack_data;
  logic        mem_stall;
  logic [31:0] mem2haz_result_frm_m, mem_result_out_reg;
  logic        mem_we_reg_file_out_reg, mem_misalign_err;

  core_mem_s dut (
    .clk(clk), .rst_n(rst_n), .mem_enb(mem_enb), .mem_kill(mem_kill),
    .mem_l1d_bus_in(mem_l1d_bus_in), .mem_addr_in(mem_addr_in), .mem_w_data_in(mem_w_data_in),
    .mem_alu_result_in(mem_alu_result_in), .mem_pc_4_in(mem_pc_4_in), .mem_wb_sx_op_in(mem_wb_sx_op_in),
    .mem_we_reg_file_in(mem_we_reg_file_in), .mem_mux_alu_mem_in(mem_mux_alu_mem_in),
    .l1d_req_val(l1d_req_val), .l1d_req_we(l1d_req_we), .l1d_req_size(l1d_req_size),
    .l1d_req_addr(l1d_req_addr), .l1d_req_wdata(l1d_req_wdata), .l1d_req_ack(l1d_req_ack),
    .l1d_ack(l1d_ack), .l1d_ack_data(l1d_ack_data), .mem_stall(mem_stall),
    .mem2haz_result_frm_m(mem2haz_result_frm_m), .mem_result_out_reg(mem_result_out_reg),
    .mem_we_reg_file_out_reg(mem_we_reg_file_out_reg), .mem_misalign_err(mem_misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic [2:0]  sx;
    logic [31:0] addr, wdata, data, alu;
    logic        we, mux;
    int          ack_dly, dat_dly;
    logic        kw, kd;
    logic [31:0] exp_res;
    logic        exp_we;
    int          exp_stall;
  } vec_t;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: pick the addressed byte/half with shifts, extend by value range.
  function automatic logic [31:0] load_val(input logic [2:0] sx, input logic [1:0] a, input logic [31:0] d);
    int unsigned b, h, ai;
    ai = a;
    b = (d >> (8 * ai)) & 32'hFF;
    h = (d >> (16 * (ai / 2))) & 32'hFFFF;
    case (sx)
      3'd1:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return h;
      default: return d;
    endcase
  endfunction

  task automatic idle_inputs();
    mem_enb = 1'b1; mem_kill = 1'b0; mem_l1d_bus_in = '0;
    mem_addr_in = '0; mem_w_data_in = '0; mem_alu_result_in = '0; mem_pc_4_in = '0;
    mem_wb_sx_op_in = '0; mem_we_reg_file_in = 1'b0; mem_mux_alu_mem_in = 1'b0;
    l1d_req_ack = 1'b0; l1d_ack = 1'b0; l1d_ack_data = '0;
  endtask

  // Drives one memory instruction to completion, checking the request fields while they are presented.
  task automatic run_txn(input vec_t v, output logic [31:0] res, output logic wo, output int stalls);
    int req_cyc, wait_cyc, cyc;
    logic acc;
    req_cyc = 0; wait_cyc = 0; cyc = 0; acc = 1'b0; stalls = 0;
    @(negedge clk);
    mem_l1d_bus_in = {3'b000, v.sz, v.wr, 1'b1};
    mem_addr_in = v.addr; mem_w_data_in = v.wdata; mem_alu_result_in = v.alu;
    mem_wb_sx_op_in = v.sx; mem_we_reg_file_in = v.we; mem_mux_alu_mem_in = v.mux;
    l1d_ack_data = v.data; mem_kill = 1'b0;
    #1;
    while (mem_stall && cyc < 40) begin
      stalls++;
      if (l1d_req_val) begin
        chk("req_fields", {l1d_req_we, l1d_req_size, l1d_req_addr, l1d_req_wdata},
            {v.wr, v.sz, v.addr, v.wdata});
        req_cyc++;
        l1d_req_ack = (req_cyc > v.ack_dly);
        if (l1d_req_ack) acc = 1'b1;
      end else begin
        l1d_req_ack = 1'b0;
      end
      @(negedge clk);
      l1d_req_ack = 1'b0;
      mem_kill = 1'b0;
      l1d_ack = 1'b0;
      // Upstream fields are scrambled: only the request buffer may matter now.
      mem_addr_in = $urandom; mem_w_data_in = $urandom;
      mem_wb_sx_op_in = 3'($urandom_range(7)); mem_we_reg_file_in = 1'($urandom_range(1));
      mem_mux_alu_mem_in = 1'($urandom_range(1));
      mem_l1d_bus_in = {3'b000, 2'($urandom_range(3)), 1'($urandom_range(1)), 1'b1};
      if (acc && !v.wr && !l1d_req_val) begin
        wait_cyc++;
        l1d_ack = (wait_cyc > v.dat_dly);
        if (wait_cyc == 1 && v.kw) mem_kill = 1'b1;
      end
      #1;
      cyc++;
    end
    if (cyc >= 40) chk("txn_timeout", 1, 0);
    chk("val_in_done", l1d_req_val, 0);
    mem_kill = v.kd;
    @(negedge clk);
    mem_kill = 1'b0; mem_l1d_bus_in = '0; l1d_ack = 1'b0;
    #1;
    res = mem_result_out_reg;
    wo = mem_we_reg_file_out_reg;
  endtask

  vec_t tbl[9];
  vec_t v;
  logic [31:0] res;
  logic wo;
  int st;

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst_result", mem_result_out_reg, 0);
    chk("rst_we", mem_we_reg_file_out_reg, 0);
    chk("rst_val", l1d_req_val, 0);
    chk("rst_err", mem_misalign_err, 0);
    chk("rst_stall", mem_stall, 0);
    #20 rst_n = 1'b1;

    //           wr   sz    sx    addr       wdata         data           alu        we   mux  ack dat kw   kd   exp_res        we   stall
    tbl[0] = '{1'b0, 2'd2, 3'd0, 32'h100, 32'h0,        32'hDEADBEEF, 32'h100, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 3};
    tbl[1] = '{1'b0, 2'd0, 3'd1, 32'h103, 32'h0,        32'h80112233, 32'h103, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 32'hFFFFFF80, 1'b1, 3};
    tbl[2] = '{1'b0, 2'd0, 3'd2, 32'h103, 32'h0,        32'h80112233, 32'h103, 1'b1, 1'b1, 1, 0, 1'b0, 1'b0, 32'h00000080, 1'b1, 4};
    tbl[3] = '{1'b0, 2'd1, 3'd3, 32'h102, 32'h0,        32'h80112233, 32'h102, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0, 32'hFFFF8011, 1'b1, 4};
    tbl[4] = '{1'b1, 2'd2, 3'd0, 32'h200, 32'h12345678, 32'h0,        32'h200, 1'b0, 1'b0, 4, 0, 1'b0, 1'b0, 32'h00000200, 1'b0, 6};
    tbl[5] = '{1'b0, 2'd1, 3'd4, 32'h100, 32'h0,        32'h1234ABCD, 32'h100, 1'b1, 1'b1, 2, 3, 1'b0, 1'b0, 32'h0000ABCD, 1'b1, 8};
    tbl[6] = '{1'b0, 2'd2, 3'd0, 32'h104, 32'h0,        32'hCAFEF00D, 32'h104, 1'b1, 1'b1, 0, 2, 1'b1, 1'b0, 32'h0,        1'b0, 5};
    tbl[7] = '{1'b0, 2'd2, 3'd0, 32'h108, 32'h0,        32'hCAFEF00D, 32'h108, 1'b1, 1'b1, 1, 1, 1'b0, 1'b1, 32'h0,        1'b0, 5};
    tbl[8] = '{1'b0, 2'd0, 3'd1, 32'h101, 32'h0,        32'h00007F00, 32'h101, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 32'h0000007F, 1'b1, 3};

    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i], res, wo, st);
      chk($sformatf("vec%0d_result", i), res, tbl[i].exp_res);
      chk($sformatf("vec%0d_we", i), wo, tbl[i].exp_we);
      chk($sformatf("vec%0d_stalls", i), st, tbl[i].exp_stall);
    end

    // Non-memory op passes straight through; mem_enb low holds the W registers.
    @(negedge clk);
    idle_inputs();
    mem_alu_result_in = 32'h55; mem_we_reg_file_in = 1'b1;
    #1;
    chk("nonmem_stall", mem_stall, 0);
    chk("nonmem_bypass", mem2haz_result_frm_m, 32'h55);
    @(negedge clk); #1;
    chk("nonmem_result", mem_result_out_reg, 32'h55);
    chk("nonmem_we", mem_we_reg_file_out_reg, 1);
    mem_enb = 1'b0; mem_alu_result_in = 32'h99;
    @(negedge clk); #1;
    chk("enb_hold", mem_result_out_reg, 32'h55);
    mem_enb = 1'b1;

    // Kill in IDLE blocks launch and bubbles W.
    mem_l1d_bus_in = 7'b0001001; mem_addr_in = 32'h300; mem_alu_result_in = 32'h33;
    mem_we_reg_file_in = 1'b1; mem_mux_alu_mem_in = 1'b1; mem_kill = 1'b1;
    #1;
    chk("kill_idle_stall", mem_stall, 0);
    @(negedge clk);
    mem_kill = 1'b0; mem_l1d_bus_in = '0;
    #1;
    chk("kill_idle_val", l1d_req_val, 0);
    chk("kill_idle_result", {mem_we_reg_file_out_reg, mem_result_out_reg}, 0);

    // Reset during WAIT abandons the load; a late l1d_ack must be ignored.
    mem_l1d_bus_in = 7'b0001001; mem_addr_in = 32'h300; mem_alu_result_in = 32'h300;
    @(negedge clk);
    l1d_req_ack = 1'b1;
    #1;
    chk("rstwait_req", l1d_req_val, 1);
    @(negedge clk);
    l1d_req_ack = 1'b0; mem_l1d_bus_in = '0; rst_n = 1'b0;
    #1;
    chk("rstwait_stall", mem_stall, 0);
    chk("rstwait_result", {mem_we_reg_file_out_reg, mem_result_out_reg}, 0);
    @(negedge clk);
    rst_n = 1'b1; mem_alu_result_in = 32'h77; mem_we_reg_file_in = 1'b1; mem_mux_alu_mem_in = 1'b0;
    l1d_ack = 1'b1; l1d_ack_data = 32'hBAD0BAD0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk("rstwait_ignore_ack", {l1d_req_val, mem_stall, mem_we_reg_file_out_reg, mem_result_out_reg},
          {1'b0, 1'b0, 1'b1, 32'h77});
    end
    l1d_ack = 1'b0;

`ifdef CORE_MEM_MISALIGN_CHK_EN
    @(negedge clk);
    mem_l1d_bus_in = 7'b0001001; mem_addr_in = 32'h102; mem_alu_result_in = 32'h102;
    mem_we_reg_file_in = 1'b1; mem_mux_alu_mem_in = 1'b1;
    #1;
    chk("mis_stall", {mem_stall, l1d_req_val}, 0);
    @(negedge clk);
    mem_l1d_bus_in = '0;
    #1;
    chk("mis_pulse", {mem_misalign_err, l1d_req_val, mem_we_reg_file_out_reg, mem_result_out_reg},
        {1'b1, 1'b0, 1'b0, 32'h0});
    @(negedge clk); #1;
    chk("mis_pulse_end", {mem_misalign_err, l1d_req_val}, 0);
`endif

    // Randomized aligned loads/stores against the model.
    for (int n = 0; n < 40; n++) begin
      v.wr = 1'($urandom_range(1));
      v.ack_dly = $urandom_range(3);
      v.dat_dly = $urandom_range(3);
      v.data = $urandom; v.wdata = $urandom;
      v.kw = ($urandom_range(5) == 0) && !v.wr;
      v.kd = ($urandom_range(7) == 0);
      if (v.wr) begin
        v.sz = 2'($urandom_range(2)); v.sx = 3'd0; v.we = 1'b0; v.mux = 1'b0;
      end else begin
        v.sx = 3'($urandom_range(4)); v.we = 1'b1; v.mux = 1'b1;
        v.sz = (v.sx == 0) ? 2'd2 : (v.sx <= 2) ? 2'd0 : 2'd1;
      end
      v.addr = $urandom & 32'h0000_FFFC;
      if (v.sz == 2'd0) v.addr = v.addr + 32'($urandom_range(3));
      if (v.sz == 2'd1) v.addr = v.addr + 32'(2 * $urandom_range(1));
      v.alu = $urandom;
      if (v.kw || v.kd) begin
        v.exp_res = 32'h0; v.exp_we = 1'b0;
      end else begin
        v.exp_res = v.mux ? load_val(v.sx, v.addr[1:0], v.data) : v.alu;
        v.exp_we = v.we;
      end
      v.exp_stall = v.wr ? 2 + v.ack_dly : 3 + v.ack_dly + v.dat_dly;
      run_txn(v, res, wo, st);
      chk($sformatf("rnd%0d_result", n), res, v.exp_res);
      chk($sformatf("rnd%0d_we", n), wo, v.exp_we);
      chk($sformatf("rnd%0d_stalls", n), st, v.exp_stall);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
